// File: rtl/gpio_int_pkg.sv
// Shared definitions for the GPIO interrupt conditioner and the interrupt controller.
// Edge-mode encodings, default widths and the channel-count derivation live here.
package gpio_int_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_LVL  = 2'b11;

  localparam int ERR_W_DEF = 2;
  localparam int INF_W_DEF = 2;
  localparam int SK_W_DEF  = 2;
  localparam int DB_W_DEF  = 4;

  // Total channel count; channel i is bit i of every packed per-channel vector.
  function automatic int int_num(input int err_w, input int inf_w, input int sk_w);
    return err_w + inf_w + sk_w;
  endfunction

endpackage

// File: rtl/gpio_int_filt_cell.sv
// One interrupt channel: 2-flop synchronizer, debounce counter and edge/level qualifier.
// The qualified output is registered on the same edge that commits the filtered level.
module gpio_int_filt_cell
  import gpio_int_pkg::*;
#(
  parameter int DB_W = DB_W_DEF
) (
  input  logic            clk_cpu,
  input  logic            rstn_cpu,
  input  logic            pin,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [DB_W-1:0] db_len,
  output logic            filt_level,
  output logic            int_out
);

  logic            s1;
  logic            s2;
  logic [DB_W-1:0] cnt;
  logic [DB_W-1:0] cnt_nxt;
  logic            filt_nxt;
  logic            commit;
  logic            qual;

  // >= rather than == so a db_len lowered mid-count commits on the next differing cycle;
  // the counter stops at db_len, so it can never wrap.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    commit   = 1'b0;
    filt_nxt = filt_level;
    cnt_nxt  = '0;
    if (s2 != filt_level) begin
      if (cnt >= db_len) begin
        commit   = 1'b1;
        filt_nxt = s2;
      end else begin
        cnt_nxt = cnt + DB_W'(1);
      end
    end
  end

  always_comb begin
    qual = 1'b0;
    case (mode)
      MODE_RISE: qual = commit &  s2;
      MODE_FALL: qual = commit & ~s2;
      MODE_BOTH: qual = commit;
      MODE_LVL:  qual = filt_nxt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so s1 -> s2 behaves as two real flops.
  always_ff @(posedge clk_cpu) begin
    if (!rstn_cpu) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      cnt        <= '0;
      filt_level <= 1'b0;
      int_out    <= 1'b0;
    end else begin
      s1         <= pin;
      s2         <= s1;
      cnt        <= cnt_nxt;
      filt_level <= filt_nxt;
      int_out    <= qual & en;
    end
  end

endmodule

// File: rtl/gpio_int_di.sv
// GPIO interrupt input conditioner: one filter cell per channel, outputs split into
// the {error, inform, shake} source vectors in the controller's collect order.
module gpio_int_di
  import gpio_int_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEF,
  parameter int INF_W = INF_W_DEF,
  parameter int SK_W  = SK_W_DEF,
  parameter int DB_W  = DB_W_DEF,
  localparam int L_INT_NUM = int_num(ERR_W, INF_W, SK_W)
) (
  input  logic                   clk_cpu,
  input  logic                   rstn_cpu,
  input  logic [L_INT_NUM-1:0]   gpio_pin,
  input  logic [L_INT_NUM-1:0]   chan_en,
  input  logic [2*L_INT_NUM-1:0] edge_mode,
  input  logic [DB_W-1:0]        db_len,
  output logic [L_INT_NUM-1:0]   filt_level,
  output logic [ERR_W-1:0]       error_int_cpu,
  output logic [INF_W-1:0]       inform_int_cpu,
  output logic [SK_W-1:0]        shake_int_cpu
);

  logic [L_INT_NUM-1:0] int_vec;

  for (genvar i = 0; i < L_INT_NUM; i++) begin : g_chan
    gpio_int_filt_cell #(
      .DB_W (DB_W)
    ) u_cell (
      .clk_cpu    (clk_cpu),
      .rstn_cpu   (rstn_cpu),
      .pin        (gpio_pin[i]),
      .en         (chan_en[i]),
      .mode       (edge_mode[2*i +: 2]),
      .db_len     (db_len),
      .filt_level (filt_level[i]),
      .int_out    (int_vec[i])
    );
  end

  assign error_int_cpu  = int_vec[L_INT_NUM-1 -: ERR_W];
  assign inform_int_cpu = int_vec[INF_W+SK_W-1 -: INF_W];
  assign shake_int_cpu  = int_vec[SK_W-1:0];

endmodule

// File: tb/tb_gpio_int_di.sv
// Directed bench for gpio_int_di: latency, glitch rejection, edge modes, enable and reset.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_gpio_int_di;

  logic        clk_cpu;
  logic        rstn_cpu;
  logic [5:0]  gpio_pin;
  logic [5:0]  chan_en;
  logic [11:0] edge_mode;
  logic [3:0]  db_len;
  logic [5:0]  filt_level;
  logic [1:0]  error_int_cpu;
  logic [1:0]  inform_int_cpu;
  logic [1:0]  shake_int_cpu;

  int checks = 0;
  int errors = 0;

  gpio_int_di dut (
    .clk_cpu        (clk_cpu),
    .rstn_cpu       (rstn_cpu),
    .gpio_pin       (gpio_pin),
    .chan_en        (chan_en),
    .edge_mode      (edge_mode),
    .db_len         (db_len),
    .filt_level     (filt_level),
    .error_int_cpu  (error_int_cpu),
    .inform_int_cpu (inform_int_cpu),
    .shake_int_cpu  (shake_int_cpu)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle just past the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_cpu);
      #1;
    end
  endtask

  logic seen;

  initial begin
    rstn_cpu  = 1'b0;
    gpio_pin  = '0;
    chan_en   = '1;
    edge_mode = '0;
    db_len    = 4'd3;
    tick(2);
    check("reset_filt",  32'(filt_level),     32'h0);
    check("reset_err",   32'(error_int_cpu),  32'h0);
    check("reset_inf",   32'(inform_int_cpu), 32'h0);
    check("reset_sk",    32'(shake_int_cpu),  32'h0);
    rstn_cpu = 1'b1;
    tick(3);

    // 1: ch0 rising, db_len=3 -> commit and pulse at edge 5.
    gpio_pin[0] = 1'b1;
    tick(5);
    check("t1_filt_e4",  32'(filt_level[0]),    32'h0);
    check("t1_sk_e4",    32'(shake_int_cpu[0]), 32'h0);
    tick(1);
    check("t1_filt_e5",  32'(filt_level[0]),    32'h1);
    check("t1_sk_e5",    32'(shake_int_cpu[0]), 32'h1);
    tick(1);
    check("t1_sk_e6",    32'(shake_int_cpu[0]), 32'h0);
    check("t1_filt_e6",  32'(filt_level[0]),    32'h1);

    // 2: ch2 glitch of 3 cycles never commits; 4 cycles commits at edge 5.
    gpio_pin[2] = 1'b1;
    tick(3);
    gpio_pin[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      seen = seen | inform_int_cpu[0] | filt_level[2];
    end
    check("t2_glitch",   32'(seen), 32'h0);
    gpio_pin[2] = 1'b1;
    tick(4);
    gpio_pin[2] = 1'b0;
    tick(1);
    check("t2_inf_e4",   32'(inform_int_cpu[0]), 32'h0);
    tick(1);
    check("t2_inf_e5",   32'(inform_int_cpu[0]), 32'h1);
    check("t2_filt_e5",  32'(filt_level[2]),     32'h1);
    tick(1);
    check("t2_inf_e6",   32'(inform_int_cpu[0]), 32'h0);
    tick(3);
    check("t2_filt_e9",  32'(filt_level[2]),     32'h0);
    check("t2_inf_e9",   32'(inform_int_cpu[0]), 32'h0);

    // 3: ch5 both-edge, db_len=0 -> pulse at edge 2 after each transition.
    edge_mode[11:10] = 2'b10;
    db_len = 4'd0;
    tick(2);
    gpio_pin[5] = 1'b1;
    tick(2);
    check("t3_r_e1",     32'(error_int_cpu[1]), 32'h0);
    tick(1);
    check("t3_r_e2",     32'(error_int_cpu[1]), 32'h1);
    check("t3_filt",     32'(filt_level[5]),    32'h1);
    tick(1);
    check("t3_r_e3",     32'(error_int_cpu[1]), 32'h0);
    tick(6);
    gpio_pin[5] = 1'b0;
    tick(2);
    check("t3_f_e1",     32'(error_int_cpu[1]), 32'h0);
    tick(1);
    check("t3_f_e2",     32'(error_int_cpu[1]), 32'h1);
    tick(1);
    check("t3_f_e3",     32'(error_int_cpu[1]), 32'h0);

    // 4: ch3 level mode, db_len=1 -> high from edge 3 until edge 3 after fall.
    edge_mode[7:6] = 2'b11;
    db_len = 4'd1;
    tick(2);
    gpio_pin[3] = 1'b1;
    tick(3);
    check("t4_e2",       32'(inform_int_cpu[1]), 32'h0);
    tick(1);
    check("t4_e3",       32'(inform_int_cpu[1]), 32'h1);
    tick(4);
    check("t4_hold",     32'(inform_int_cpu[1]), 32'h1);
    gpio_pin[3] = 1'b0;
    tick(3);
    check("t4_f_e2",     32'(inform_int_cpu[1]), 32'h1);
    tick(1);
    check("t4_f_e3",     32'(inform_int_cpu[1]), 32'h0);

    // 5: ch1 rising while disabled -> no pulse, even after re-enable.
    db_len = 4'd3;
    chan_en[1] = 1'b0;
    gpio_pin[1] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      seen = seen | shake_int_cpu[1];
    end
    chan_en[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      seen = seen | shake_int_cpu[1];
    end
    check("t5_no_pulse", 32'(seen),          32'h0);
    check("t5_filt",     32'(filt_level[1]), 32'h1);

    // 6: reset while ch4's counter sits at 2, then a fresh pulse after release.
    gpio_pin[4] = 1'b1;
    tick(4);
    rstn_cpu = 1'b0;
    tick(1);
    rstn_cpu = 1'b1;
    check("t6_rst_filt", 32'(filt_level),     32'h0);
    check("t6_rst_err",  32'(error_int_cpu),  32'h0);
    check("t6_rst_inf",  32'(inform_int_cpu), 32'h0);
    check("t6_rst_sk",   32'(shake_int_cpu),  32'h0);
    tick(1);
    check("t6_post_err", 32'(error_int_cpu),  32'h0);
    check("t6_post_sk",  32'(shake_int_cpu),  32'h0);
    tick(4);
    check("t6_err_e4",   32'(error_int_cpu[0]), 32'h0);
    tick(1);
    check("t6_err_e5",   32'(error_int_cpu[0]), 32'h1);
    check("t6_sk_e5",    32'(shake_int_cpu),    32'h3);
    check("t6_filt_e5",  32'(filt_level),       32'h13);
    tick(1);
    check("t6_err_e6",   32'(error_int_cpu[0]), 32'h0);
    check("t6_sk_e6",    32'(shake_int_cpu),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_int_di.md
Name: gpio_int_di

Overview:
Interrupt input conditioner that sits directly upstream of the CPU interrupt controller. It takes raw asynchronous GPIO pins and, per channel, does three things: a 2-flop synchronize, a programmable-length debounce, and edge/level qualification. The results are emitted as the error/inform/shake interrupt-source vectors the controller's ISR consumes. Channel ordering is {error, inform, shake}, MSB first, matching the controller's collect order.

Parameters:
ERR_W, 2, number of error interrupt channels
INF_W, 2, number of information interrupt channels
SK_W, 2, number of handshake interrupt channels
DB_W, 4, width of debounce length and per-channel counter
(derived localparam L_INT_NUM = ERR_W+INF_W+SK_W; channel i = bit i of packed vector)

Ports:
clk_cpu  in  1  single clock, all logic on rising edge
rstn_cpu  in  1  reset, synchronous, active-low
gpio_pin  in  L_INT_NUM  raw asynchronous pins {err,inf,sk}
chan_en  in  L_INT_NUM  per-channel output enable
edge_mode  in  2*L_INT_NUM  channel i at [2i+1:2i]: 00 rising, 01 falling, 10 both, 11 level-high
db_len  in  DB_W  debounce length N; commit requires N+1 consecutive differing synced samples
filt_level  out  L_INT_NUM  debounced level per channel
error_int_cpu  out  ERR_W  interrupt source = out[L_INT_NUM-1:INF_W+SK_W]
inform_int_cpu  out  INF_W  = out[INF_W+SK_W-1:SK_W]
shake_int_cpu  out  SK_W  = out[SK_W-1:0]

Behaviour:
- Reset is synchronous and active-low. While rstn_cpu=0 at a clock edge, all registers clear: sync stages, filt_level, counters and interrupt outputs are all 0.
- Synchronizer: s1 <= gpio_pin; s2 <= s1. Nothing downstream uses s1.
- Debounce, per channel, evaluated each cycle:
  - s2==filt_level: cnt <= 0.
  - s2!=filt_level and cnt>=db_len: filt_level <= s2 (commit), cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - The comparison is >= so that lowering db_len mid-count commits on the next differing cycle. The counter never wraps.
- Glitch rejection: a pulse shorter than db_len+1 synced cycles never commits, and its counter returns to 0 as soon as s2 matches filt_level again.
- Edge qualification: registered at the same edge as the commit.
  - Rising: commit 0->1.
  - Falling: commit 1->0.
  - Both: either commit.
  - Each qualifying commit gives exactly a 1-cycle pulse.
- Level-high mode: the output equals the registered filt_level. The output is held while the level holds.
- Enable: output bit = qualified & chan_en. The filter keeps running when disabled, so re-enabling never produces a spurious edge. A chan_en or edge_mode change takes effect on the next commit or level evaluation; there is no retroactive pulse.
- Latency: let edge 0 be the first clock edge at which s1 samples a new pin value that then stays stable.
  - filt_level updates and the pulse register sets at edge 2+db_len.
  - The output is high between edge 2+db_len and edge 3+db_len.
- After reset, filt_level=0. A pin held high through reset release yields a rising-edge pulse (or level assertion) after the normal latency. This is intended, so the ISR captures pending sources.
- Channels are fully independent. Simultaneous commits on several channels yield simultaneous pulses; priority is resolved downstream.
- Reset asserted mid-count or mid-pulse: everything returns to 0 at that edge, with no pulse in the following cycle.

Decomposition:
- Shared package gpio_int_pkg holds:
  - edge-mode localparams MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_LVL=2'b11;
  - default DB_W;
  - the L_INT_NUM derivation.
- The controller shares the same package.
- One sub-module, gpio_int_filt_cell, contains the sync, debounce counter and edge qualifier for one channel. The top generates L_INT_NUM instances and splits the packed output into the three source vectors.

Test Plan:
1. db_len=3, ch0 rising, en=1. gpio_pin[0] goes 0->1 and holds -> filt_level[0] rises at edge 5, and shake_int_cpu[0] is high for exactly one cycle after edge 5.
2. db_len=3. Glitch of 3 cycles high on ch2 -> no commit, no pulse, cnt back to 0. Repeat with 4 cycles high -> pulse at edge 5.
3. ch5 in both-edge mode, db_len=0. Pin 0->1, hold 10 cycles, then 1->0 -> error_int_cpu[1] pulses at edge 2 after each transition; two pulses total.
4. ch3 in level mode, db_len=1. Pin high 8 cycles -> inform_int_cpu[1] high from edge 3 until 3 edges after the pin falls.
5. ch1 rising, en=0 during the 0->1 commit, en=1 afterwards -> no pulse ever, and filt_level[1]=1.
6. rstn_cpu=0 for one edge while ch4's counter is at 2 -> all outputs 0 next cycle. Pin still high after reset -> fresh rising pulse at edge 2+db_len after release.
